icache_nway: RTL
================

# icache_nway

Parametrised N-way set-associative, read-only instruction cache with tree pseudo-LRU replacement and a whole-cache invalidate (flush) for fence.i. It sits between the fetch stage and the instruction-side physical memory port (or arbiter). It returns one 32-bit word per hit and refills a full line on a miss. It generalises the 2-way instruction cache to any power-of-two way count and set count.

## Interface
- S_OFFSET, 5: line offset bits. Line is 2**S_OFFSET bytes; S_LINE = 8*2**S_OFFSET bits.
- S_INDEX, 3: index bits. NUM_SETS = 2**S_INDEX.
- NUM_WAYS, 4: associativity. Power of two, 2..8.
- S_TAG, 32-S_OFFSET-S_INDEX: tag width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  fetch request. Held with mem_address stable until mem_resp.
- mem_address  in  32  byte address (word-aligned).
- flush  in  1  one-cycle pulse. Invalidates all lines.
- mem_rdata  out  32  requested word. Driven 0 when mem_resp=0.
- mem_resp  out  1  request complete this cycle.
- pmem_read  out  1  line fill request. Held until pmem_resp.
- pmem_address  out  32  line-aligned fill address {tag,index,S_OFFSET'b0}.
- pmem_rdata  in  S_LINE  fill data. Valid with pmem_resp.
- pmem_resp  in  1  fill complete.
- hit_count, miss_count  out  32 each  present only with ICACHE_PERF_EN.

## Operation
- Storage is flop arrays per way: valid[NUM_SETS], tag[NUM_SETS], data[NUM_SETS]. Each set has an (NUM_WAYS-1)-bit PLRU tree. All reads are asynchronous.
- FSM has two states, IDLE and FETCH.
- IDLE:
  - With mem_read and no flush, compare the tag against all ways.
  - Hit: mem_resp=1 combinationally. mem_rdata = hit-way line word mem_address[S_OFFSET-1:2]. The PLRU is updated at the clock edge.
  - Miss: register the line address and the victim way, then go to FETCH.
- FETCH:
  - pmem_read=1 and pmem_address come from a register.
  - On pmem_resp: write pmem_rdata, tag and valid=1 into the victim way, update the PLRU, return to IDLE.
  - The re-lookup then hits.
- Victim selection: the lowest-numbered invalid way; if all ways are valid, the PLRU victim.
- PLRU:
  - A node bit of 0 points the victim toward the lower half.
  - On access to way w, every node on w's path is set to point away from w.
- Flush in IDLE:
  - Has priority over mem_read: mem_resp=0 and no miss starts that cycle.
  - At the edge, all valid bits and all PLRU bits clear.
- Flush in FETCH:
  - Latched as flush_pending.
  - The refill completes and writes data, but at that edge all valid bits (including the new line) and PLRU bits clear. flush_pending clears.
  - The pending request re-misses.
- Reset: state IDLE, all valid=0, PLRU=0, flush_pending=0, counters 0. mem_resp=0, pmem_read=0, mem_rdata=0.
- rst during FETCH aborts the refill. pmem_read drops the next cycle and a late pmem_resp in IDLE is ignored.

## Timing
- Hit latency is 0 cycles: mem_resp in the same cycle as mem_read. Back-to-back hits run 1 per cycle.
- Miss sequence:
  - The miss is detected in cycle 0.
  - pmem_read rises in cycle 1.
  - The pmem_resp cycle R writes the arrays.
  - mem_resp is asserted in cycle R+1.
- pmem_address is constant for the whole FETCH and does not depend on mem_address after cycle 0.
- Simultaneous flush and a hit in IDLE: flush wins and there is no response.

## Configuration
- ICACHE_PERF_EN defined:
  - hit_count and miss_count ports and 32-bit wrapping counters exist.
  - miss_count increments on each IDLE->FETCH transition.
  - hit_count increments on mem_resp, except the first response after a refill (tracked by a registered refilled flag).
- ICACHE_PERF_EN undefined: the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Shared package cache_types holds:
  - the icache_state_t enum {IDLE, FETCH};
  - the function plru_bits(num_ways) returning NUM_WAYS-1;
  - S_LINE derivation constants.
- One sub-module, plru_tree #(NUM_WAYS):
  - combinational victim index from the tree bits;
  - next-tree-bits function from the accessed way.

## Test plan
Parameters for all scenarios: NUM_WAYS=4, S_INDEX=3, pmem latency 3 cycles.

- After reset, read 0x0000_0004:
  - pmem_read with pmem_address=0x0000_0000 in cycle 1.
  - Fill word1=0x1111_1111; mem_resp with mem_rdata=0x1111_1111 the cycle after pmem_resp.
- Read 0x0000_0008 next cycle: mem_resp the same cycle, pmem_read stays 0.
- PLRU victim:
  - Fill set 0 with 0x000, 0x100, 0x200, 0x300 (ways 0-3), then hit 0x000, then 0x200.
  - Read 0x400: way 1 (0x100) is evicted.
  - 0x000 then hits; 0x100 misses.
- Flush pulse after fills with mem_read=0: a following read of 0x0000_0000 misses with pmem_address=0x0000_0000.
- Flush asserted in FETCH cycle 2: the refill completes without mem_resp, and a second pmem_read for the same address follows.
- With ICACHE_PERF_EN, after scenarios 1-2: hit_count=1, miss_count=1. After rst, both read 0.

Source files
------------

// File: rtl/icache_nway_pkg.sv
// Shared types and helpers for the N-way instruction cache.
// Holds the FSM state encoding, the PLRU tree width helper and line-size
// derivation used by icache_nway and plru_tree.
package cache_types;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  localparam int WORD_BITS = 32;

  // A binary PLRU tree over num_ways leaves has num_ways-1 internal nodes.
  function automatic int plru_bits(input int num_ways);
    return num_ways - 1;
  endfunction

  // Line width in bits for a line of 2**s_offset bytes.
  function automatic int line_bits(input int s_offset);
    return 8 * (2 ** s_offset);
  endfunction

endpackage

// File: rtl/icache_nway_plru.sv
// plru_tree: tree pseudo-LRU helper for one cache set.
// Nodes are heap-ordered (root 0, children 2n+1 / 2n+2). A node bit of 0
// steers the victim toward the lower half. An access to a way sets every
// node on that way's path to point away from it.
module plru_tree
  import cache_types::*;
#(
  parameter int  NUM_WAYS = 4,
  localparam int WAY_W    = $clog2(NUM_WAYS),
  localparam int TREE_W   = plru_bits(NUM_WAYS)
) (
  input  logic [TREE_W-1:0] tree,
  input  logic [WAY_W-1:0]  access_way,
  output logic [WAY_W-1:0]  victim,
  output logic [TREE_W-1:0] tree_next
);

  int vnode;
  int unode;

  // Walk from the root following the node bits to find the victim leaf.
  always_comb begin
    vnode  = 0;
    victim = '0;
    for (int l = 0; l < WAY_W; l++) begin
      victim[WAY_W-1-l] = tree[vnode];
      vnode = 2 * vnode + 1 + int'(tree[vnode]);
    end
  end

  // Walk the accessed way's path, pointing each node at the other half.
  always_comb begin
    unode     = 0;
    tree_next = tree;
    for (int l = 0; l < WAY_W; l++) begin
      tree_next[unode] = ~access_way[WAY_W-1-l];
      unode = 2 * unode + 1 + int'(access_way[WAY_W-1-l]);
    end
  end

endmodule

// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative read-only instruction cache.
// Zero-latency hits, full-line refill on miss, tree PLRU replacement and a
// whole-cache flush for fence.i. Optional hit/miss counters are built when
// ICACHE_PERF_EN is defined.
// Handshake: mem_read is held with a stable mem_address until mem_resp;
// pmem_read is held with a stable pmem_address until pmem_resp.
module icache_nway
  import cache_types::*;
#(
  parameter int  S_OFFSET = 5,
  parameter int  S_INDEX  = 3,
  parameter int  NUM_WAYS = 4,
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX,
  localparam int S_LINE   = line_bits(S_OFFSET)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic [31:0]       mem_address,
  input  logic              flush,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic [31:0]       pmem_address,
  input  logic [S_LINE-1:0] pmem_rdata,
  input  logic              pmem_resp
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam int WAY_W    = $clog2(NUM_WAYS);
  localparam int TREE_W   = plru_bits(NUM_WAYS);
  localparam int S_WORD   = S_OFFSET - 2;

  icache_state_t state_q, state_d;

  logic [NUM_SETS-1:0] valid_q [NUM_WAYS];
  logic [S_TAG-1:0]    tag_q   [NUM_WAYS][NUM_SETS];
  logic [S_LINE-1:0]   data_q  [NUM_WAYS][NUM_SETS];
  logic [TREE_W-1:0]   plru_q  [NUM_SETS];

  logic [31:0]      line_addr_q;
  logic [WAY_W-1:0] victim_q;
  logic             flush_pending_q;

  logic [S_INDEX-1:0] req_index, fill_index;
  logic [S_TAG-1:0]   req_tag, fill_tag;
  logic [S_WORD-1:0]  req_word;
  logic               hit, has_invalid;
  logic [WAY_W-1:0]   hit_way, inv_way, plru_victim, plru_way;
  logic [TREE_W-1:0]  plru_tree_in, plru_tree_next;
  logic               lookup, hit_fire, miss_fire, fill_fire, clear_all;
  logic               unused_addr_bits;

  assign req_index  = mem_address[S_OFFSET +: S_INDEX];
  assign req_tag    = mem_address[31 -: S_TAG];
  assign req_word   = mem_address[S_OFFSET-1:2];
  assign fill_index = line_addr_q[S_OFFSET +: S_INDEX];
  assign fill_tag   = line_addr_q[31 -: S_TAG];
  assign unused_addr_bits = ^mem_address[1:0];

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[w][req_index] && (tag_q[w][req_index] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest-numbered invalid way in the addressed set, if any.
  always_comb begin
    has_invalid = 1'b0;
    inv_way     = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][req_index]) begin
        has_invalid = 1'b1;
        inv_way     = WAY_W'(w);
      end
    end
  end

  // During FETCH the tree of the refilled set is updated for the victim way;
  // in IDLE the addressed set supplies the victim and takes the hit update.
  assign plru_tree_in = (state_q == FETCH) ? plru_q[fill_index] : plru_q[req_index];
  assign plru_way     = (state_q == FETCH) ? victim_q : hit_way;

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .tree       (plru_tree_in),
    .access_way (plru_way),
    .victim     (plru_victim),
    .tree_next  (plru_tree_next)
  );

  // Flush outranks a lookup; a flush seen during FETCH is applied at refill.
  assign lookup    = (state_q == IDLE) && mem_read && !flush;
  assign hit_fire  = lookup && hit;
  assign miss_fire = lookup && !hit;
  assign fill_fire = (state_q == FETCH) && pmem_resp;
  assign clear_all = ((state_q == IDLE) && flush) ||
                     (fill_fire && (flush_pending_q || flush));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_fire) state_d = FETCH;
      FETCH:   if (pmem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: hit response in IDLE, held fill request in FETCH.
  always_comb begin
    mem_resp     = hit_fire;
    mem_rdata    = '0;
    pmem_read    = (state_q == FETCH);
    pmem_address = line_addr_q;
    if (hit_fire) mem_rdata = data_q[hit_way][req_index][{req_word, 5'b0} +: WORD_BITS];
  end

  // Miss bookkeeping: line address, victim way and deferred flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_addr_q     <= '0;
      victim_q        <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      if (miss_fire) begin
        line_addr_q <= {req_tag, req_index, S_OFFSET'(0)};
        victim_q    <= has_invalid ? inv_way : plru_victim;
      end
      if (fill_fire)                      flush_pending_q <= 1'b0;
      else if (state_q == FETCH && flush) flush_pending_q <= 1'b1;
    end
  end

  // Valid bits and PLRU trees; a flush clears both, including a fresh fill.
  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      for (int w = 0; w < NUM_WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
    end else if (fill_fire) begin
      valid_q[victim_q][fill_index] <= 1'b1;
      plru_q[fill_index]            <= plru_tree_next;
    end else if (hit_fire) begin
      plru_q[req_index] <= plru_tree_next;
    end
  end

  // Tag and data arrays are written on every completed refill.
  always_ff @(posedge clk) begin
    if (fill_fire) begin
      data_q[victim_q][fill_index] <= pmem_rdata;
      tag_q[victim_q][fill_index]  <= fill_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  logic refilled_q;

  // Hit/miss counters; the response that completes a refill is not a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      refilled_q <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (fill_fire)     refilled_q <= 1'b1;
      else if (hit_fire) refilled_q <= 1'b0;
      if (hit_fire && !refilled_q) hit_count  <= hit_count + 32'd1;
      if (miss_fire)               miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
